// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the datapath controller.
// Contents: the NOP and HALT instruction encodings and the instruction format codes.
// The format code sits in the two least significant bits of an instruction word.
package instr_fetch_unit_pkg;

    localparam logic [15:0] CPU_NOP_WORD  = 16'h0003;
    localparam logic [15:0] CPU_HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        FmtAlu = 2'b00,
        FmtImm = 2'b01,
        FmtNop = 2'b11
    } inst_fmt_e;

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter register for the fetch unit.
// Ports:
//   clk  in           clock, rising edge
//   rst  in           asynchronous, active-high reset (pc -> 0)
//   clr  in           synchronous clear to 0 (takes priority over inc)
//   inc  in           advance by one, wrapping from 2**ADDR_W-1 to 0
//   pc   out ADDR_W   current value
module instr_fetch_unit_pc_counter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d, pc_q;

    // The add is truncated to ADDR_W bits, which gives the wrap for free.
    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads 16-bit words from a synchronous ROM and feeds them to the
// multicycle controller, one instruction per 6-cycle controller round (S2..S7).
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            1-cycle pulse, begins execution at pc=0 from IDLE or HALTED
//   done_in          controller done, high in S7; used to align and to advance the pc
//   step             (FETCH_STEP_EN only) 1-cycle pulse releasing one more instruction
//   mem_req/mem_addr ROM read strobe and address (address is always pc)
//   mem_rdata        ROM data, valid the cycle after mem_req
//   inst_out         instruction presented to the controller
//   run              execute enable, high only in EXEC
//   pc               program counter
//   halted           HALT_WORD was fetched; cleared by start or rst
// Build option: define FETCH_STEP_EN to add the step input and the PAUSE state
// (single-instruction stepping). Without it the fetch loop free-runs.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [15:0] HALT_WORD = CPU_HALT_WORD,
    parameter logic [15:0] NOP_WORD  = CPU_NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done_in,
`ifdef FETCH_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       inst_out,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSync   = 3'd1;
    localparam logic [2:0] StFetch  = 3'd2;
    localparam logic [2:0] StLoad   = 3'd3;
    localparam logic [2:0] StExec   = 3'd4;
    localparam logic [2:0] StHalted = 3'd5;
`ifdef FETCH_STEP_EN
    localparam logic [2:0] StPause  = 3'd6;
`endif

    logic [2:0]  state_d, state_q;
    logic [15:0] inst_d, inst_q;
    logic        halted_d, halted_q;
    logic        pc_clr, pc_inc;
`ifdef FETCH_STEP_EN
    logic        step_pending_d, step_pending_q;
`endif

    always_comb begin
        state_d  = state_q;
        inst_d   = inst_q;
        halted_d = halted_q;
        pc_clr   = 1'b0;
        pc_inc   = 1'b0;
`ifdef FETCH_STEP_EN
        // Capture a step in any cycle, so one coinciding with done_in is not lost.
        step_pending_d = step_pending_q | step;
`endif
        case (state_q)
            StIdle: begin
                // start beats a simultaneous done_in; alignment waits for the next one.
                if (start) begin
                    pc_clr  = 1'b1;
                    state_d = StSync;
`ifdef FETCH_STEP_EN
                    step_pending_d = 1'b0;
`endif
                end
            end
            StSync: begin
                if (done_in) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                // A HALT word never reaches the controller; it sees a NOP instead.
                if (mem_rdata == HALT_WORD) begin
                    inst_d   = NOP_WORD;
                    halted_d = 1'b1;
                    state_d  = StHalted;
                end else begin
                    inst_d  = mem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (done_in) begin
                    pc_inc = 1'b1;
`ifdef FETCH_STEP_EN
                    inst_d  = NOP_WORD;
                    state_d = StPause;
`else
                    state_d = StFetch;
`endif
                end
            end
            StHalted: begin
                if (start) begin
                    halted_d = 1'b0;
                    pc_clr   = 1'b1;
                    state_d  = StSync;
`ifdef FETCH_STEP_EN
                    step_pending_d = 1'b0;
`endif
                end
            end
`ifdef FETCH_STEP_EN
            StPause: begin
                if (step_pending_d) begin
                    step_pending_d = 1'b0;
                    state_d        = StSync;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            inst_q   <= NOP_WORD;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            halted_q <= halted_d;
        end
    end

`ifdef FETCH_STEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_pending_q <= 1'b0;
        end else begin
            step_pending_q <= step_pending_d;
        end
    end
`endif

    instr_fetch_unit_pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc_counter (
        .clk (clk),
        .rst (rst),
        .clr (pc_clr),
        .inc (pc_inc),
        .pc  (pc)
    );

    assign mem_req  = (state_q == StFetch);
    assign mem_addr = pc;
    assign inst_out = inst_q;
    assign run      = (state_q == StExec);
    assign halted   = halted_q;

endmodule
